// File: rtl/ps2_scan_decoder.sv
// Turns a PS/2 Set-2 scan-code byte stream into {code, ext, brk} key events
// queued in a small first-word-fall-through FIFO; handles Pause and timeouts.
module ps2_scan_decoder #(
    parameter int DEPTH_LOG2 = 2,
    parameter int TIMEOUT    = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_byte,
    input  logic       ev_rd,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       ev_full,
    output logic       overflow,
    output logic       seq_err
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [TW-1:0]       TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      skip_q, skip_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            seq_err_q, seq_err_d;
    logic            ovf_q, ovf_d;
    logic            push;
    logic [9:0]      push_data;
    logic            idle_path;

    logic [9:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  full, pop, wr_en;
    logic [9:0]            head;

    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        tmo_d     = tmo_q;
        seq_err_d = 1'b0;
        push      = 1'b0;
        push_data = '0;
        idle_path = 1'b0;
        if (rx_done_tick) begin
            tmo_d = '0;
            case (state_q)
                S_IDLE: idle_path = 1'b1;
                S_EXT: begin
                    if (rx_byte == 8'hF0) begin
                        state_d = S_EXT_BRK;
                    end else if (rx_byte == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (rx_byte == 8'hE1) begin
                        seq_err_d = 1'b1;
                        state_d   = S_PAUSE;
                        skip_d    = 3'd7;
                    end else begin
                        push      = 1'b1;
                        push_data = {1'b1, 1'b0, rx_byte};
                        state_d   = S_IDLE;
                    end
                end
                S_BRK, S_EXT_BRK: begin
                    // A stray prefix after F0 restarts decoding with that byte
                    if (rx_byte inside {8'hE0, 8'hF0, 8'hE1}) begin
                        seq_err_d = 1'b1;
                        idle_path = 1'b1;
                    end else begin
                        push      = 1'b1;
                        push_data = {(state_q == S_EXT_BRK), 1'b1, rx_byte};
                        state_d   = S_IDLE;
                    end
                end
                S_PAUSE: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        push      = 1'b1;
                        push_data = {1'b1, 1'b0, 8'hE1};
                        state_d   = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (idle_path) begin
                state_d = S_IDLE;
                if (rx_byte == 8'hE0) begin
                    state_d = S_EXT;
                end else if (rx_byte == 8'hF0) begin
                    state_d = S_BRK;
                end else if (rx_byte == 8'hE1) begin
                    state_d = S_PAUSE;
                    skip_d  = 3'd7;
                end else if (!(rx_byte inside {8'h00, 8'hAA, 8'hEE, 8'hFA,
                                               8'hFC, 8'hFD, 8'hFE, 8'hFF})) begin
                    push      = 1'b1;
                    push_data = {1'b0, 1'b0, rx_byte};
                end
            end
        end else if (state_q != S_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                seq_err_d = 1'b1;
                state_d   = S_IDLE;
                tmo_d     = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    assign full  = (count_q == FULL_CNT);
    assign pop   = ev_rd && (count_q != '0);
    assign wr_en = push && (!full || pop);
    assign ovf_d = ovf_q || (push && full && !pop);

    always_comb begin
        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + (DEPTH_LOG2 + 1)'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - (DEPTH_LOG2 + 1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            skip_q    <= '0;
            tmo_q     <= '0;
            seq_err_q <= 1'b0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            skip_q    <= skip_d;
            tmo_q     <= tmo_d;
            seq_err_q <= seq_err_d;
            ovf_q     <= ovf_d;
            count_q   <= count_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data;
    end

    // Storage is not reset, so the head is masked while the FIFO is empty
    assign head     = mem_q[rd_ptr_q];
    assign ev_valid = (count_q != '0);
    assign ev_code  = ev_valid ? head[7:0] : 8'h00;
    assign ev_break = ev_valid ? head[8]   : 1'b0;
    assign ev_ext   = ev_valid ? head[9]   : 1'b0;
    assign ev_full  = full;
    assign overflow = ovf_q;
    assign seq_err  = seq_err_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Self-checking bench for ps2_scan_decoder: directed scenarios plus a random
// byte stream compared against a prefix-flag reference model.
module tb_ps2_scan_decoder;
    localparam int DL  = 2;
    localparam int TMO = 100;
    localparam int CAP = 1 << DL;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       ev_rd = 1'b0;
    logic       ev_valid, ev_ext, ev_break, ev_full, overflow, seq_err;
    logic [7:0] ev_code;

    int checks = 0;
    int errors = 0;

    typedef logic [9:0] ev_t;
    ev_t q[$];
    bit  m_ext, m_brk, m_ovf, exp_err, seen_err;
    int  m_pause;

    ps2_scan_decoder #(.DEPTH_LOG2(DL), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_byte(rx_byte),
        .ev_rd(ev_rd), .ev_valid(ev_valid), .ev_code(ev_code), .ev_ext(ev_ext),
        .ev_break(ev_break), .ev_full(ev_full), .overflow(overflow), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    function automatic bit is_ignored(input logic [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
    endfunction

    // Reference: a pending-prefix pair of flags plus a Pause byte countdown
    function automatic void model_byte(input logic [7:0] b, output bit push,
                                       output ev_t ev, output bit err);
        bit pfx;
        push = 0; ev = '0; err = 0;
        pfx = (b == 8'hE0) || (b == 8'hF0) || (b == 8'hE1);
        if (m_pause > 0) begin
            m_pause--;
            if (m_pause == 0) begin push = 1; ev = {2'b10, 8'hE1}; end
            return;
        end
        if (m_ext && !m_brk) begin
            if (b == 8'hF0) begin m_brk = 1; return; end
            if (b == 8'hE0) return;
            if (b == 8'hE1) begin err = 1; m_ext = 0; m_pause = 7; return; end
            push = 1; ev = {2'b10, b}; m_ext = 0;
            return;
        end
        if (m_brk) begin
            if (!pfx) begin
                push = 1; ev = {m_ext, 1'b1, b}; m_ext = 0; m_brk = 0;
                return;
            end
            err = 1; m_ext = 0; m_brk = 0;
        end
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE1) m_pause = 7;
        else if (!is_ignored(b)) begin push = 1; ev = {2'b00, b}; end
    endfunction

    function automatic void model_clear();
        q.delete();
        m_ext = 0; m_brk = 0; m_ovf = 0; exp_err = 0; m_pause = 0;
    endfunction

    task automatic cycle(input bit tick, input logic [7:0] b, input bit rd);
        bit push, err, popping;
        ev_t ev;
        rx_done_tick = tick; rx_byte = b; ev_rd = rd;
        @(posedge clk);
        push = 0; err = 0; ev = '0;
        if (tick) model_byte(b, push, ev, err);
        popping = rd && (q.size() > 0);
        if (push && q.size() == CAP && !popping) begin
            m_ovf = 1;
        end else begin
            if (popping) void'(q.pop_front());
            if (push) q.push_back(ev);
        end
        exp_err = err;
        #1;
        rx_done_tick = 0; rx_byte = 8'h00; ev_rd = 0;
        seen_err = seen_err | seq_err;
    endtask

    task automatic send(input logic [7:0] b);
        cycle(1'b1, b, 1'b0);
    endtask

    task automatic do_reset();
        rx_done_tick = 0; ev_rd = 0; rx_byte = 8'h00;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_clear();
        seen_err = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({ev_valid, ev_full, overflow, seq_err, ev_ext, ev_break, ev_code} !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0",
                     {ev_valid, ev_full, overflow, seq_err, ev_ext, ev_break, ev_code});
        end
        do_reset();
    endtask

    task automatic test_make_break();
        do_reset();
        send(8'h1C); cycle(0, 8'h00, 0); send(8'hF0); send(8'h1C); cycle(0, 8'h00, 0);
        checks++;
        if ({ev_valid, ev_ext, ev_break, ev_code} !== {3'b100, 8'h1C}) begin
            errors++;
            $display("FAIL make_head: got %b required %b", {ev_valid, ev_ext, ev_break, ev_code}, {3'b100, 8'h1C});
        end
        cycle(0, 8'h00, 1);
        checks++;
        if ({ev_valid, ev_ext, ev_break, ev_code} !== {3'b101, 8'h1C}) begin
            errors++;
            $display("FAIL break_head: got %b required %b", {ev_valid, ev_ext, ev_break, ev_code}, {3'b101, 8'h1C});
        end
        cycle(0, 8'h00, 1);
        checks++;
        if ({ev_valid, seen_err} !== 2'b00) begin
            errors++;
            $display("FAIL make_break_tail: got valid,err=%b required 00", {ev_valid, seen_err});
        end
    endtask

    task automatic test_ext();
        do_reset();
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        checks++;
        if ({ev_valid, ev_ext, ev_break, ev_code} !== {3'b110, 8'h75}) begin
            errors++;
            $display("FAIL ext_make: got %b required %b", {ev_valid, ev_ext, ev_break, ev_code}, {3'b110, 8'h75});
        end
        cycle(0, 8'h00, 1);
        checks++;
        if ({ev_valid, ev_ext, ev_break, ev_code} !== {3'b111, 8'h75}) begin
            errors++;
            $display("FAIL ext_break: got %b required %b", {ev_valid, ev_ext, ev_break, ev_code}, {3'b111, 8'h75});
        end
        cycle(0, 8'h00, 1);
        checks++;
        if ({ev_valid, seen_err} !== 2'b00) begin
            errors++;
            $display("FAIL ext_tail: got valid,err=%b required 00", {ev_valid, seen_err});
        end
    endtask

    task automatic test_pause();
        logic [7:0] seq [10] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'hFA, 8'hAA};
        do_reset();
        foreach (seq[i]) send(seq[i]);
        checks++;
        if ({ev_valid, ev_ext, ev_break, ev_code} !== {3'b110, 8'hE1}) begin
            errors++;
            $display("FAIL pause_event: got %b required %b", {ev_valid, ev_ext, ev_break, ev_code}, {3'b110, 8'hE1});
        end
        cycle(0, 8'h00, 1);
        checks++;
        if ({ev_valid, seen_err} !== 2'b00) begin
            errors++;
            $display("FAIL pause_single: got valid,err=%b required 00", {ev_valid, seen_err});
        end
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        do_reset();
        foreach (codes[i]) send(codes[i]);
        checks++;
        if ({ev_full, overflow} !== 2'b11) begin
            errors++;
            $display("FAIL ovf_flags: got full,ovf=%b required 11", {ev_full, overflow});
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({ev_valid, ev_code} !== {1'b1, codes[i]}) begin
                errors++;
                $display("FAIL ovf_pop%0d: got %h required %h", i, {ev_valid, ev_code}, {1'b1, codes[i]});
            end
            cycle(0, 8'h00, 1);
        end
        checks++;
        if ({ev_valid, overflow} !== 2'b01) begin
            errors++;
            $display("FAIL ovf_drained: got valid,ovf=%b required 01", {ev_valid, overflow});
        end
        cycle(1, 8'h16, 1);
        checks++;
        if ({ev_valid, ev_code} !== {1'b1, 8'h16}) begin
            errors++;
            $display("FAIL push_empty_pop: got %h required %h", {ev_valid, ev_code}, {1'b1, 8'h16});
        end
        do_reset();
        for (int i = 0; i < 4; i++) send(codes[i]);
        cycle(1, 8'h35, 1);
        checks++;
        if ({ev_full, overflow, ev_code} !== {2'b10, 8'h1D}) begin
            errors++;
            $display("FAIL full_push_pop: got %b required %b", {ev_full, overflow, ev_code}, {2'b10, 8'h1D});
        end
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1);
        checks++;
        if ({ev_valid, ev_code} !== {1'b1, 8'h35}) begin
            errors++;
            $display("FAIL full_push_pop_tail: got %h required %h", {ev_valid, ev_code}, {1'b1, 8'h35});
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send(8'hF0);
        for (int k = 0; k <= 101; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            checks++;
            if (seq_err !== (k == 100)) begin
                errors++;
                $display("FAIL timeout_k%0d: got seq_err=%b required %b", k, seq_err, (k == 100));
            end
        end
        m_brk = 0;
        send(8'h1C);
        checks++;
        if ({ev_valid, ev_ext, ev_break, ev_code} !== {3'b100, 8'h1C}) begin
            errors++;
            $display("FAIL after_timeout: got %b required %b", {ev_valid, ev_ext, ev_break, ev_code}, {3'b100, 8'h1C});
        end
        do_reset();
        send(8'hF0);
        repeat (99) @(posedge clk);
        #1;
        send(8'h1C);
        cycle(0, 8'h00, 0); cycle(0, 8'h00, 0);
        checks++;
        if ({seen_err, ev_valid, ev_ext, ev_break, ev_code} !== {4'b0101, 8'h1C}) begin
            errors++;
            $display("FAIL byte_wins: got %b required %b", {seen_err, ev_valid, ev_ext, ev_break, ev_code}, {4'b0101, 8'h1C});
        end
    endtask

    task automatic test_seq_err();
        do_reset();
        send(8'hF0); send(8'hE0);
        checks++;
        if (seq_err !== 1'b1) begin
            errors++;
            $display("FAIL brk_prefix_err: got %b required 1", seq_err);
        end
        send(8'h75);
        checks++;
        if ({seq_err, ev_valid, ev_ext, ev_break, ev_code} !== {4'b0110, 8'h75}) begin
            errors++;
            $display("FAIL brk_prefix_recover: got %b required %b", {seq_err, ev_valid, ev_ext, ev_break, ev_code}, {4'b0110, 8'h75});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(8'hF0); send(8'h2C); send(8'hF0); send(8'hE0);
        reset = 1'b1;
        #1;
        checks++;
        if ({ev_valid, ev_full, overflow, seq_err, ev_ext, ev_break, ev_code} !== 14'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %b required 0",
                     {ev_valid, ev_full, overflow, seq_err, ev_ext, ev_break, ev_code});
        end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        send(8'h75);
        checks++;
        if ({ev_valid, ev_ext, ev_break, ev_code} !== {3'b100, 8'h75}) begin
            errors++;
            $display("FAIL reset_mid_next: got %b required %b", {ev_valid, ev_ext, ev_break, ev_code}, {3'b100, 8'h75});
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic [13:0] expv;
        int r;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 19);
            case (r)
                0, 1:    b = 8'hE0;
                2, 3:    b = 8'hF0;
                4:       b = 8'hE1;
                5:       b = 8'hFA;
                6:       b = 8'hAA;
                default: b = 8'($urandom_range(1, 8'h83));
            endcase
            cycle($urandom_range(0, 9) < 7, b, $urandom_range(0, 3) == 0);
            expv = {q.size() != 0, q.size() == CAP, m_ovf, exp_err,
                    (q.size() != 0) ? q[0] : 10'h000};
            checks++;
            if ({ev_valid, ev_full, overflow, seq_err, ev_ext, ev_break, ev_code} !== expv) begin
                errors++;
                $display("FAIL random_step%0d: got %b required %b", n,
                         {ev_valid, ev_full, overflow, seq_err, ev_ext, ev_break, ev_code}, expv);
            end
        end
    endtask

    initial begin
        model_clear();
        seen_err = 0;
        test_reset();
        test_make_break();
        test_ext();
        test_pause();
        test_overflow();
        test_timeout();
        test_seq_err();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_scan_decoder.md
# ps2_scan_decoder

Consumes the byte stream from the PS/2 receiver (`rx_done_tick` plus 8-bit `dout`) and turns Set-2 scan-code sequences into discrete key events. Each event carries a code, an extended flag and a break flag. Events are queued in a small first-word-fall-through FIFO that the keyboard/application logic drains at its own pace. The block also discards non-key bytes, collapses the 8-byte Pause sequence into one event, and recovers from truncated sequences with a timeout.

## Interface
- `DEPTH_LOG2`, 2, log2 of event FIFO depth (default 4 entries).
- `TIMEOUT`, 2000000, idle clocks inside a partial sequence before abort (20 ms at 100 MHz).
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_done_tick`  in  1  one-cycle pulse; `rx_byte` valid this cycle.
- `rx_byte`  in  8  received byte from the PS/2 receiver.
- `ev_rd`  in  1  pop the head event; ignored when `ev_valid`=0.
- `ev_valid`  out  1  FIFO not empty.
- `ev_code`  out  8  head event code.
- `ev_ext`  out  1  head event is extended (E0-prefixed, or Pause).
- `ev_break`  out  1  head event is a release.
- `ev_full`  out  1  FIFO full.
- `overflow`  out  1  sticky; an event was dropped because the FIFO was full; cleared only by reset.
- `seq_err`  out  1  one-cycle pulse on a malformed or timed-out sequence.

## Operation
- Reset values:
  - FSM in IDLE.
  - FIFO empty: `ev_valid`=0, `ev_full`=0.
  - `ev_code`=0, `ev_ext`=0, `ev_break`=0.
  - `overflow`=0, `seq_err`=0, timeout counter=0.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE. Transitions are evaluated only on `rx_done_tick`, except timeout.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> PAUSE, skip counter=7.
  - 00, AA, EE, FA, FC, FD, FE, FF -> ignored, stay IDLE.
  - Any other byte -> push {code=byte, ext=0, brk=0}, stay IDLE.
- EXT:
  - F0 -> EXT_BRK.
  - E0 -> stay EXT.
  - E1 -> `seq_err`, go to PAUSE, skip=7.
  - Other byte -> push {byte, ext=1, brk=0} -> IDLE.
- BRK:
  - E0, F0 or E1 -> `seq_err`, then handled as if received in IDLE.
  - Other byte -> push {byte, 0, 1} -> IDLE.
- EXT_BRK:
  - E0, F0 or E1 -> `seq_err`, then handled as if received in IDLE.
  - Other byte -> push {byte, 1, 1} -> IDLE.
- PAUSE:
  - Each byte decrements skip; contents are not checked.
  - When the 7th byte arrives (skip==1): push {E1, 1, 0} -> IDLE.
- Timeout:
  - The counter clears on every `rx_done_tick` and whenever the state is IDLE; otherwise it increments.
  - When it reaches `TIMEOUT`: `seq_err` pulse, state -> IDLE, counter -> 0, no event.
- FIFO: 10-bit entries {ext, brk, code}; head is presented combinationally from the read pointer.
  - Push with FIFO full and no pop: event dropped, `overflow` set.
  - Push and pop in the same cycle while full: both happen; occupancy unchanged; no overflow.
  - Push while empty with `ev_rd`=1: the pop is ignored and the push is accepted.
  - Pointers wrap modulo 2^`DEPTH_LOG2`. Occupancy uses a `DEPTH_LOG2`+1-bit count.

## Timing
- The decision is combinational on the `rx_done_tick` cycle N. The FIFO write happens at the end of cycle N, so `ev_valid`/head are visible in cycle N+1 when the FIFO was empty.
- `seq_err` is registered and asserted in cycle N+1 for exactly one cycle.
- `ev_rd` in cycle M advances the head; the next entry, or `ev_valid`=0, is visible in M+1.
- If `rx_done_tick` coincides with the timeout cycle, the byte wins: the counter clears, the byte is decoded normally, and there is no `seq_err`.
- Back-to-back `rx_done_tick` on consecutive cycles must be supported. The upstream receiver cannot produce this, but the bench drives it.
- Asserting `reset` mid-sequence or with a non-empty FIFO returns to the reset values immediately, with no event emitted.

## Test plan
- Bytes 1C, F0, 1C -> two events: {1C,0,0} then {1C,0,1}; `seq_err` never pulses.
- Bytes E0 75, E0 F0 75 (up arrow) -> events {75,1,0} then {75,1,1}.
- Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event {E1,1,0}. Also FA and AA alone -> no event.
- Five make codes 15,1D,24,2D,2C with `ev_rd`=0 (DEPTH_LOG2=2) -> `ev_full`=1, `overflow`=1, and the head reads 15,1D,24,2D on pops. Then a push with simultaneous pop at full -> accepted, `overflow` unchanged.
- Byte F0 then no traffic (`TIMEOUT`=100 in the bench) -> `seq_err` pulse 101 cycles after the byte. A following 1C -> {1C,0,0}, not a break.
- Byte E0 followed by `reset` pulse, then 75 -> event {75,0,0}; all outputs zero during reset.
